// File: rtl/fpu_mac_sequencer.sv
// Sequencing controller for a 3x3 column-sliding filter MAC array.
// It accepts a strip of columns, keeps a 3-column window and holds the taps for the strip.
// It tracks the fixed MAC latency and buffers results in a fall-through output FIFO.
module fpu_mac_sequencer #(
  parameter int unsigned COL_WIDTH   = 10,
  parameter int unsigned MAC_LATENCY = 2,
  parameter int unsigned OUT_DEPTH   = 4,
  parameter int unsigned WIDTH_BITS  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [WIDTH_BITS-1:0]         img_width_i,
  input  logic [8:0][7:0]               filter_in_i,
  input  logic [COL_WIDTH-1:0][7:0]     col_in_i,
  input  logic                          col_valid_i,
  output logic                          col_ready_o,
  output logic [COL_WIDTH-1:0][7:0]     col0_o,
  output logic [COL_WIDTH-1:0][7:0]     col1_o,
  output logic [COL_WIDTH-1:0][7:0]     col2_o,
  output logic [8:0][7:0]               filter_o,
  input  logic [COL_WIDTH-3:0][7:0]     mac_result_i,
  output logic [COL_WIDTH-3:0][7:0]     out_pixels_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned PtrW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned InflW = $clog2(MAC_LATENCY + 1);

  typedef enum logic [2:0] {StIdle, StFill, StRun, StDrain, StDone} state_e;
  typedef logic [COL_WIDTH-1:0][7:0] col_t;
  typedef logic [COL_WIDTH-3:0][7:0] res_t;

  state_e                 state_q, state_d;
  logic [WIDTH_BITS-1:0]  width_q, width_d;
  logic [8:0][7:0]        filter_q, filter_d;
  col_t                   col0_q, col1_q, col2_q;
  col_t                   col0_d, col1_d, col2_d;
  logic [WIDTH_BITS-1:0]  cols_in_q, cols_in_d;
  logic [WIDTH_BITS-1:0]  cols_out_q, cols_out_d;
  logic [MAC_LATENCY-1:0] pipe_q, pipe_d;
  res_t                   fifo_mem_q [OUT_DEPTH];
  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic             start_acc, accept, launch, push, pop, credit_ok;
  logic [InflW-1:0] inflight;

  assign start_acc = (state_q == StIdle) && start_i;
  assign accept    = col_valid_i && col_ready_o;
  // The third fill accept and every run accept complete a window worth computing.
  assign launch    = accept && ((state_q == StRun) || (cols_in_q == WIDTH_BITS'(2)));
  assign push      = pipe_q[MAC_LATENCY-1];
  assign pop       = (cnt_q != '0) && out_ready_i;
  // Reserve a FIFO slot for every operation still in the MAC pipe.
  assign credit_ok = (32'(cnt_q) + 32'(inflight)) < OUT_DEPTH;

  // Count operations currently travelling through the MAC array.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAC_LATENCY; i++) begin
      inflight = inflight + InflW'(pipe_q[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = (img_width_i < WIDTH_BITS'(3)) ? StDone : StFill;
        end
      end
      StFill: begin
        if (accept && (cols_in_q == WIDTH_BITS'(2))) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (cols_in_d == width_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if ((cols_out_q == width_q - WIDTH_BITS'(2)) && (pipe_q == '0) && (cnt_q == '0)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    col_ready_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != StIdle);
    unique case (state_q)
      StFill:  col_ready_o = 1'b1;
      StRun:   col_ready_o = credit_ok && (cols_in_q < width_q);
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Strip parameters, window, counters, launch pipe and FIFO pointers next state.
  always_comb begin
    width_d    = width_q;
    filter_d   = filter_q;
    col0_d     = col0_q;
    col1_d     = col1_q;
    col2_d     = col2_q;
    cols_in_d  = cols_in_q;
    cols_out_d = cols_out_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    pipe_d     = MAC_LATENCY'({pipe_q, launch});
    if (start_acc) begin
      width_d    = img_width_i;
      filter_d   = filter_in_i;
      cols_in_d  = '0;
      cols_out_d = '0;
    end
    if (accept) begin
      col0_d    = col1_q;
      col1_d    = col2_q;
      col2_d    = col_in_i;
      cols_in_d = cols_in_q + WIDTH_BITS'(1);
    end
    if (pop) begin
      cols_out_d = cols_out_q + WIDTH_BITS'(1);
      rptr_d     = (rptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    if (push) begin
      wptr_d = (wptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Datapath and control registers; reset discards any partial strip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q    <= '0;
      filter_q   <= '0;
      col0_q     <= '0;
      col1_q     <= '0;
      col2_q     <= '0;
      cols_in_q  <= '0;
      cols_out_q <= '0;
      pipe_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      width_q    <= width_d;
      filter_q   <= filter_d;
      col0_q     <= col0_d;
      col1_q     <= col1_d;
      col2_q     <= col2_d;
      cols_in_q  <= cols_in_d;
      cols_out_q <= cols_out_d;
      pipe_q     <= pipe_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage; occupancy lives in cnt_q, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= mac_result_i;
    end
  end

  assign out_valid_o  = (cnt_q != '0);
  assign out_pixels_o = fifo_mem_q[rptr_q];
  assign col0_o       = col0_q;
  assign col1_o       = col1_q;
  assign col2_o       = col2_q;
  assign filter_o     = filter_q;

  // The credit check on col_ready must keep the FIFO from ever overflowing.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CntW'(OUT_DEPTH))));

endmodule

// File: tb/tb_fpu_mac_sequencer.sv
// Self-checking bench for fpu_mac_sequencer with a behavioural MAC array model.
module tb_fpu_mac_sequencer;

  localparam int unsigned CW = 10;
  localparam int unsigned ML = 2;
  localparam int unsigned OD = 4;
  localparam int unsigned WB = 10;

  typedef logic [CW-1:0][7:0] col_t;
  typedef logic [CW-3:0][7:0] res_t;
  typedef logic [8:0][7:0]    taps_t;
  typedef struct {
    int width;
    bit ident;
    bit stall;
    int bp;
    bit inject;
    int exp_outs;
    int exp_hold_acc;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WB-1:0] img_width;
  taps_t         filter_in;
  col_t          col_in;
  logic          col_valid;
  logic          col_ready;
  col_t          col0, col1, col2;
  taps_t         filt;
  res_t          mac_q;
  res_t          out_pixels;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   accepted;
  bit   saw_ready;
  int   n_out, n_done, first_valid_cyc, third_acc_cyc;
  res_t exp_q[$];
  col_t cols[16];

  fpu_mac_sequencer #(
    .COL_WIDTH  (CW),
    .MAC_LATENCY(ML),
    .OUT_DEPTH  (OD),
    .WIDTH_BITS (WB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .img_width_i (img_width),
    .filter_in_i (filter_in),
    .col_in_i    (col_in),
    .col_valid_i (col_valid),
    .col_ready_o (col_ready),
    .col0_o      (col0),
    .col1_o      (col1),
    .col2_o      (col2),
    .filter_o    (filt),
    .mac_result_i(mac_q),
    .out_pixels_o(out_pixels),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mac_f(input col_t c0, input col_t c1, input col_t c2, input taps_t f);
    res_t r;
    int   acc;
    for (int p = 0; p < CW - 2; p++) begin
      acc = 0;
      for (int i = 0; i < 3; i++) begin
        acc += int'($signed(f[i*3]))   * int'(c0[p+i])
             + int'($signed(f[i*3+1])) * int'(c1[p+i])
             + int'($signed(f[i*3+2])) * int'(c2[p+i]);
      end
      r[p] = acc[7:0];
    end
    return r;
  endfunction

  // MAC array model: one register stage, so the result is ready ML-1 edges after the window.
  always_ff @(posedge clk) mac_q <= mac_f(col0, col1, col2, filt);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bookkeeping for the coming edge, then advance to the next falling edge.
  task automatic step();
    accepted = col_valid && col_ready;
    if (col_ready) saw_ready = 1'b1;
    if (done) n_done++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected output: got %0h expected none", out_pixels);
      end else begin
        check("out_pixels", out_pixels, exp_q.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic fill_cols(input bit ident);
    for (int k = 0; k < 16; k++) begin
      for (int r = 0; r < CW; r++) begin
        cols[k][r] = ident ? k[7:0] : 8'($urandom);
      end
    end
  endtask

  function automatic taps_t make_taps(input bit ident);
    taps_t t;
    t = '0;
    if (ident) t[4] = 8'd1;
    else for (int i = 0; i < 9; i++) t[i] = 8'($urandom);
    return t;
  endfunction

  task automatic push_expected(input int width, input taps_t taps);
    for (int k = 0; k + 2 < width; k++) begin
      exp_q.push_back(mac_f(cols[k], cols[k+1], cols[k+2], taps));
    end
  endtask

  task automatic run_strip(input vec_t v);
    taps_t taps, alt;
    int    idx, acc_hold;
    bit    fin;
    fill_cols(v.ident);
    taps = make_taps(v.ident);
    alt  = make_taps(1'b0);
    exp_q.delete();
    push_expected(v.width, taps);
    n_out = 0; n_done = 0; saw_ready = 1'b0;
    first_valid_cyc = -1; third_acc_cyc = -1; acc_hold = -1;
    start     = 1'b1;
    img_width = WB'(v.width);
    filter_in = taps;
    col_valid = 1'b0;
    out_ready = (v.bp == 0);
    step();
    start     = 1'b0;
    img_width = WB'(9);
    filter_in = alt;
    check("filter latched", filt, taps);
    idx = 0;
    fin = 1'b0;
    for (int lc = 0; lc < 600 && !fin; lc++) begin
      start     = v.inject && (lc == 6);
      col_valid = (idx < v.width) && !(v.stall && lc[0]);
      col_in    = cols[idx % 16];
      out_ready = (lc >= v.bp);
      if (v.bp > 0 && lc == v.bp) acc_hold = idx;
      step();
      if (accepted) begin
        idx++;
        if (idx == 3) third_acc_cyc = cyc - 1;
      end
      fin = (n_done != 0);
    end
    start     = 1'b0;
    col_valid = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL strip timeout: got no done, required done within 600 cycles");
    end
    check("busy low after done", busy, 1'b0);
    check("columns accepted", idx, (v.width < 3) ? 0 : v.width);
    step();
    check("output count", n_out, v.exp_outs);
    check("done pulse count", n_done, 1);
    check("scoreboard drained", exp_q.size(), 0);
    check("filter held", filt, taps);
    if (v.width < 3) check("no col_ready", saw_ready, 1'b0);
    if (v.bp == 0 && v.width >= 3) check("first result latency", first_valid_cyc - third_acc_cyc, ML + 1);
    if (v.exp_hold_acc >= 0) check("accepts under backpressure", acc_hold, v.exp_hold_acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t after_rst;
    taps_t taps;
    int idx;
    tbl[0] = '{width: 5,  ident: 1'b1, stall: 1'b0, bp: 0,  inject: 1'b0, exp_outs: 3,  exp_hold_acc: -1};
    tbl[1] = '{width: 12, ident: 1'b0, stall: 1'b0, bp: 30, inject: 1'b0, exp_outs: 10, exp_hold_acc: 2 + OD};
    tbl[2] = '{width: 2,  ident: 1'b0, stall: 1'b0, bp: 0,  inject: 1'b0, exp_outs: 0,  exp_hold_acc: -1};
    tbl[3] = '{width: 3,  ident: 1'b0, stall: 1'b0, bp: 0,  inject: 1'b0, exp_outs: 1,  exp_hold_acc: -1};
    tbl[4] = '{width: 6,  ident: 1'b0, stall: 1'b1, bp: 0,  inject: 1'b0, exp_outs: 4,  exp_hold_acc: -1};
    tbl[5] = '{width: 7,  ident: 1'b0, stall: 1'b0, bp: 0,  inject: 1'b1, exp_outs: 5,  exp_hold_acc: -1};
    after_rst = '{width: 8, ident: 1'b0, stall: 1'b0, bp: 0, inject: 1'b0, exp_outs: 6, exp_hold_acc: -1};

    rst_n = 1'b0; start = 1'b0; img_width = '0; filter_in = '0;
    col_in = '0; col_valid = 1'b0; out_ready = 1'b0;
    #3;
    check("reset out_valid", out_valid, 1'b0);
    check("reset col_ready", col_ready, 1'b0);
    check("reset busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) run_strip(tbl[t]);

    // Reset in the middle of an 8-column strip, after 5 accepts.
    fill_cols(1'b0);
    taps = make_taps(1'b0);
    exp_q.delete();
    push_expected(8, taps);
    n_out = 0; n_done = 0; first_valid_cyc = -1;
    start = 1'b1; img_width = WB'(8); filter_in = taps; out_ready = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    for (int lc = 0; lc < 40 && idx < 5; lc++) begin
      col_valid = 1'b1;
      col_in    = cols[idx];
      step();
      if (accepted) idx++;
    end
    col_valid = 1'b0;
    check("columns before reset", idx, 5);
    check("busy mid-strip", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset col_ready", col_ready, 1'b0);
    check("mid reset busy", busy, 1'b0);
    check("mid reset done", done, 1'b0);
    check("mid reset col0", col0, '0);
    check("mid reset col1", col1, '0);
    check("mid reset col2", col2, '0);
    check("mid reset filter", filt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    run_strip(after_rst);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
